// File: rtl/sha256_digest_accum.sv
// Chaining-value and digest accumulator for a Bitcoin double SHA-256: sequences
// header block 0, header block 1 and the second hash block, folding a..h into H0..H7.
module sha256_digest_accum #(
    parameter logic [31:0] IV0 = 32'h6a09e667,
    parameter logic [31:0] IV1 = 32'hbb67ae85,
    parameter logic [31:0] IV2 = 32'h3c6ef372,
    parameter logic [31:0] IV3 = 32'ha54ff53a,
    parameter logic [31:0] IV4 = 32'h510e527f,
    parameter logic [31:0] IV5 = 32'h9b05688c,
    parameter logic [31:0] IV6 = 32'h1f83d9ab,
    parameter logic [31:0] IV7 = 32'h5be0cd19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         reuse_mid,
    input  logic         round_done,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [31:0]  e,
    input  logic [31:0]  f,
    input  logic [31:0]  g,
    input  logic [31:0]  h,
    input  logic [6:0]   select,
    input  logic [255:0] target,
    output logic [31:0]  h1,
    output logic [31:0]  h2,
    output logic [31:0]  h3,
    output logic [31:0]  h4,
    output logic [31:0]  h5,
    output logic [31:0]  h6,
    output logic [31:0]  h7,
    output logic [31:0]  h8,
    output logic [1:0]   block,
    output logic [31:0]  message_hash,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         hit,
    output logic         midstate_valid
);

    localparam int NUM_WORDS = 8;

    // Index 0 is H0 and sits in the most significant bits when flattened.
    typedef logic [0:NUM_WORDS-1][31:0] words_t;

    typedef enum logic [2:0] {
        IDLE, BLK0, ACC0, BLK1, ACC1, BLK2, ACC2, DONE
    } state_t;

    localparam words_t IV = {IV0, IV1, IV2, IV3, IV4, IV5, IV6, IV7};

    state_t       state;
    words_t       hv;
    words_t       cap;
    words_t       mid;
    words_t       dig1;
    words_t       sum;
    logic [255:0] sum_flat;
    logic [255:0] sum_rev;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_add
            assign sum[gi] = hv[gi] + cap[gi];
        end
    endgenerate

    assign sum_flat = sum;

    // Whole-digest byte reversal: the last digest byte becomes the MSB byte.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev
            assign sum_rev[8*gi +: 8] = sum_flat[255-8*gi -: 8];
        end
    endgenerate

    assign h1 = hv[0];
    assign h2 = hv[1];
    assign h3 = hv[2];
    assign h4 = hv[3];
    assign h5 = hv[4];
    assign h6 = hv[5];
    assign h7 = hv[6];
    assign h8 = hv[7];

    // Padded 256-bit message for the second hash: digest1, 1-bit, zeros, length 256.
    always_comb begin
        message_hash = 32'h0;
        if (select < 7'd8)
            message_hash = dig1[select[2:0]];
        else if (select == 7'd8)
            message_hash = 32'h80000000;
        else if (select == 7'd15)
            message_hash = 32'h00000100;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hv             <= IV;
            cap            <= '0;
            mid            <= '0;
            dig1           <= '0;
            digest         <= '0;
            digest_valid   <= 1'b0;
            hit            <= 1'b0;
            busy           <= 1'b0;
            midstate_valid <= 1'b0;
            block          <= 2'd0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    if (reuse_mid && midstate_valid) begin
                        hv    <= mid;
                        block <= 2'd1;
                        state <= BLK1;
                    end else begin
                        hv    <= IV;
                        block <= 2'd0;
                        state <= BLK0;
                    end
                end
                BLK0: if (round_done) begin
                    cap   <= {a, b, c, d, e, f, g, h};
                    state <= ACC0;
                end
                BLK1: if (round_done) begin
                    cap   <= {a, b, c, d, e, f, g, h};
                    state <= ACC1;
                end
                BLK2: if (round_done) begin
                    cap   <= {a, b, c, d, e, f, g, h};
                    state <= ACC2;
                end
                ACC0: begin
                    mid            <= sum;
                    midstate_valid <= 1'b1;
                    hv             <= sum;
                    block          <= 2'd1;
                    state          <= BLK1;
                end
                ACC1: begin
                    dig1  <= sum;
                    hv    <= IV;
                    block <= 2'd2;
                    state <= BLK2;
                end
                ACC2: begin
                    digest       <= sum_flat;
                    hit          <= (sum_rev < target);
                    digest_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    block <= 2'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_digest_accum.sv
// Bench for sha256_digest_accum: a behavioural round datapath runs the genesis
// header through the DUT; a monitor scores each digest_valid against a queue.
module tb_sha256_digest_accum;

    typedef logic [0:7][31:0]  h_t;
    typedef logic [0:15][31:0] blk_t;
    typedef struct {
        logic [255:0] dig;
        logic         hit;
        int           t0;
        int           lat;
    } exp_t;

    localparam int D = 20;   // bench datapath dwell in every BLKn state

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, reuse_mid = 1'b0, round_done = 1'b0;
    logic [31:0]  ra = '0, rb = '0, rc = '0, rd = '0, re = '0, rf = '0, rg = '0, rh = '0;
    logic [6:0]   sel = '0;
    logic [255:0] target = '0;
    logic [31:0]  h1, h2, h3, h4, h5, h6, h7, h8, message_hash;
    logic [1:0]   block;
    logic         busy, digest_valid, hit, midstate_valid;
    logic [255:0] digest;

    sha256_digest_accum dut (
        .clk(clk), .rst(rst), .start(start), .reuse_mid(reuse_mid), .round_done(round_done),
        .a(ra), .b(rb), .c(rc), .d(rd), .e(re), .f(rf), .g(rg), .h(rh),
        .select(sel), .target(target),
        .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7), .h8(h8),
        .block(block), .message_hash(message_hash), .busy(busy), .digest(digest),
        .digest_valid(digest_valid), .hit(hit), .midstate_valid(midstate_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errs = 0;
    int   checks = 0;
    exp_t sb_q[$];

    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    h_t   IVW = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    blk_t B0 = {32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
                32'h888a5132, 32'h3a9fb8aa};
    blk_t B1 = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c, 32'h80000000,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h00000280};
    logic [255:0] GEN_DISP = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

    h_t           mid_m, d1_m;
    logic [255:0] gen_raw, tgt_hi, tgt_one;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Final round-64 working variables a..h for one block (no feed-forward).
    function automatic h_t compress(input h_t hin, input blk_t m);
        logic [31:0] w [64];
        logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {va, vb, vc, vd, ve, vf, vg, vh} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = vh + (ror(ve, 6) ^ ror(ve, 11) ^ ror(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + K[i] + w[i];
            t2 = (ror(va, 2) ^ ror(va, 13) ^ ror(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
            vh = vg; vg = vf; vf = ve; ve = vd + t1;
            vd = vc; vc = vb; vb = va; va = t1 + t2;
        end
        return {va, vb, vc, vd, ve, vf, vg, vh};
    endfunction

    function automatic h_t hadd(input h_t x, input h_t y);
        h_t r;
        for (int i = 0; i < 8; i++) r[i] = x[i] + y[i];
        return r;
    endfunction

    function automatic logic [255:0] byterev(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input int k);
        if (k < 8) return d1_m[k];
        if (k == 8) return 32'h80000000;
        if (k == 15) return 32'h00000100;
        return 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every digest_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && digest_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errs++;
                $display("FAIL spurious_digest_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                exp_t ex;
                ex = sb_q.pop_front();
                chk("digest", digest, ex.dig);
                chk("hit", {255'b0, hit}, {255'b0, ex.hit});
                chk("latency", 256'(cyc - ex.t0), 256'(ex.lat));
            end
        end
    end

    task automatic do_start(input logic reuse, input logic [255:0] tgt,
                            input logic ehit, input int elat);
        target = tgt; start = 1'b1; reuse_mid = reuse;
        @(negedge clk);
        start = 1'b0; reuse_mid = 1'b0;
        sb_q.push_back('{gen_raw, ehit, cyc, elat});
        chk("busy_after_start", {255'b0, busy}, 256'd1);
    endtask

    // Behaves as the round datapath for one block; entered in the block's first cycle.
    task automatic run_block(input int n, input h_t exp_h, input logic spur_start);
        h_t   hin, ah;
        blk_t w;
        chk($sformatf("block%0d", n), 256'(block), 256'(n));
        hin = '0; w = (n == 0) ? B0 : (n == 1) ? B1 : '0;
        for (int k = 0; k < D; k++) begin
            sel = 7'(k);
            if (spur_start && k == 3) start = 1'b1;
            if (spur_start && k == 4) start = 1'b0;
            #1;
            if (k == 1) begin
                hin = {h1, h2, h3, h4, h5, h6, h7, h8};
                chk($sformatf("chain_in_blk%0d", n), hin, exp_h);
            end
            if (n == 2 && k <= 16)
                chk($sformatf("msg_word%0d", k), 256'(message_hash), 256'(exp_word(k)));
            if (n == 2 && k < 16) w[k] = message_hash;
            if (k == D - 1) begin
                ah = compress(hin, w);
                {ra, rb, rc, rd, re, rf, rg, rh} = ah;
                round_done = 1'b1;
            end
            @(negedge clk);
        end
        round_done = 1'b0;
        {ra, rb, rc, rd, re, rf, rg, rh} = '0;
        @(negedge clk);
    endtask

    initial begin
        mid_m   = hadd(IVW, compress(IVW, B0));
        d1_m    = hadd(mid_m, compress(mid_m, B1));
        gen_raw = byterev(GEN_DISP);
        tgt_hi  = 256'd1 << 224;
        tgt_one = 256'd1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_h1", 256'(h1), 256'(32'h6a09e667));
        chk("rst_h8", 256'(h8), 256'(32'h5be0cd19));
        chk("rst_block", 256'(block), 256'd0);
        chk("rst_busy", {255'b0, busy}, 256'd0);
        chk("rst_midvalid", {255'b0, midstate_valid}, 256'd0);
        chk("rst_digest", digest, 256'd0);

        // H0 add wraps: 6a09e667 + 95f61999 = 2^32.
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("wrap_block0", 256'(block), 256'd0);
        ra = 32'h95f61999; round_done = 1'b1;
        @(negedge clk);
        ra = '0; round_done = 1'b0;
        @(negedge clk);
        chk("wrap_h1", 256'(h1), 256'd0);
        chk("wrap_h2", 256'(h2), 256'(32'hbb67ae85));
        chk("wrap_midvalid", {255'b0, midstate_valid}, 256'd1);
        chk("wrap_block1", 256'(block), 256'd1);

        // Abort mid-BLK1 with an asynchronous reset.
        rst = 1'b1; #1;
        chk("abort_h1", 256'(h1), 256'(32'h6a09e667));
        chk("abort_block", 256'(block), 256'd0);
        chk("abort_busy", {255'b0, busy}, 256'd0);
        chk("abort_midvalid", {255'b0, midstate_valid}, 256'd0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // reuse_mid without a valid midstate still runs block 0; spurious start in BLK2.
        do_start(1'b1, tgt_hi, 1'b1, 3 + 3*D);
        run_block(0, IVW, 1'b0);
        run_block(1, mid_m, 1'b0);
        run_block(2, IVW, 1'b1);
        round_done = 1'b1; start = 1'b1;    // both land in the DONE cycle
        @(negedge clk);
        start = 1'b0;                       // round_done stays high through IDLE
        chk("done_start_ignored", {255'b0, busy}, 256'd0);
        @(negedge clk);
        round_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_after_spurious", {255'b0, busy}, 256'd0);
        chk("midvalid_kept", {255'b0, midstate_valid}, 256'd1);

        do_start(1'b0, tgt_one, 1'b0, 3 + 3*D);
        run_block(0, IVW, 1'b0);
        run_block(1, mid_m, 1'b0);
        run_block(2, IVW, 1'b0);
        repeat (3) @(negedge clk);

        do_start(1'b1, tgt_one, 1'b0, 2 + 2*D);
        run_block(1, mid_m, 1'b0);
        run_block(2, IVW, 1'b0);
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 256'(sb_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
